id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: field extraction, immediate generation,
// WB bypass, load-use stall detection and the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           if_pc_i,
  input  logic [31:0]           if_instr_i,
  input  logic                  flush_i,
  input  logic                  ex_mem_read_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [4:0]            rf_rs1_addr_o,
  output logic [4:0]            rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,
  output logic                  stall_o,
  output logic [31:0]           id_pc_o,
  output logic [DATA_WIDTH-1:0] id_rs1_data_o,
  output logic [DATA_WIDTH-1:0] id_rs2_data_o,
  output logic [31:0]           id_imm_o,
  output logic [4:0]            id_rs1_o,
  output logic [4:0]            id_rs2_o,
  output logic [4:0]            id_rd_o,
  output logic [2:0]            id_funct3_o,
  output logic [3:0]            id_alu_op_o,
  output logic                  id_alu_src_a_o,
  output logic                  id_alu_src_b_o,
  output logic                  id_mem_read_o,
  output logic                  id_mem_write_o,
  output logic                  id_reg_write_o,
  output logic [1:0]            id_wb_sel_o,
  output logic                  id_branch_o,
  output logic                  id_jump_o,
  output logic                  id_jalr_o,
  output logic                  id_illegal_o
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // All RV32I opcodes end in 2'b11, so any other low bits fall to the default arm.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [31:0]           imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    alu_op_e               alu_op;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    wb_sel_e               wb_sel;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic                  illegal;
  } idex_t;

  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  arith_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [2:0]  funct3_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic        use_rs1, use_rs2, writes_rd, known, active;
  logic        load_use;
  idex_t       dec, idex_d, idex_q;

  assign opcode   = if_instr_i[6:0];
  assign rd_f     = if_instr_i[11:7];
  assign funct3_f = if_instr_i[14:12];
  assign rs1_f    = if_instr_i[19:15];
  assign rs2_f    = if_instr_i[24:20];

  assign rf_rs1_addr_o = rs1_f;
  assign rf_rs2_addr_o = rs2_f;

  assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
  assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
  assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                  if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign imm_u = {if_instr_i[31:12], 12'd0};
  assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                  if_instr_i[20], if_instr_i[30:21], 1'b0};

  // The register file is written at the end of this cycle, so a same-cycle
  // WB to a source register must be forwarded around it.
  assign rs1_val = (rs1_f == 5'd0) ? '0 :
                   (wb_we_i && (wb_rd_i == rs1_f)) ? wb_data_i : rf_rs1_data_i;
  assign rs2_val = (rs2_f == 5'd0) ? '0 :
                   (wb_we_i && (wb_rd_i == rs2_f)) ? wb_data_i : rf_rs2_data_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    dec       = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    known     = 1'b1;
    active    = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec.imm       = imm_u;
        dec.alu_op    = ALU_PASSB;
        dec.alu_src_b = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec.imm       = imm_j;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.jump      = 1'b1;
        dec.wb_sel    = WB_PC4;
        writes_rd     = 1'b1;
      end
      OPC_JALR: begin
        dec.imm       = imm_i;
        dec.funct3    = funct3_f;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_b = 1'b1;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.wb_sel    = WB_PC4;
        use_rs1       = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.funct3 = funct3_f;
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm       = imm_i;
        dec.funct3    = funct3_f;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_b = 1'b1;
        dec.mem_read  = 1'b1;
        dec.wb_sel    = WB_MEM;
        use_rs1       = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        dec.imm       = imm_s;
        dec.funct3    = funct3_f;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm       = imm_i;
        dec.funct3    = funct3_f;
        dec.alu_op    = arith_op(funct3_f, if_instr_i[30], 1'b0);
        dec.alu_src_b = 1'b1;
        use_rs1       = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_OP: begin
        dec.funct3 = funct3_f;
        dec.alu_op = arith_op(funct3_f, if_instr_i[30], 1'b1);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        writes_rd  = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: active = 1'b0;
      default: begin
        known  = 1'b0;
        active = 1'b0;
      end
    endcase

    if (active) begin
      dec.pc        = if_pc_i;
      dec.rs1       = use_rs1 ? rs1_f : 5'd0;
      dec.rs2       = use_rs2 ? rs2_f : 5'd0;
      dec.rs1_data  = use_rs1 ? rs1_val : '0;
      dec.rs2_data  = use_rs2 ? rs2_val : '0;
      dec.rd        = writes_rd ? rd_f : 5'd0;
      dec.reg_write = writes_rd && (rd_f != 5'd0);
    end
    dec.illegal = !known && (if_instr_i != 32'd0);
  end

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((use_rs1 && (ex_rd_i == rs1_f)) || (use_rs2 && (ex_rd_i == rs2_f)));

  // A flush kills this instruction anyway, so holding IF for it is pointless.
  assign stall_o = rst_n && !flush_i && load_use;

  assign idex_d = (flush_i || load_use) ? '0 : dec;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only at the clock edge, so rst_n stays out of the
    // sensitivity list; state updates use <= so all flops see pre-edge values.
    if (!rst_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign id_pc_o        = idex_q.pc;
  assign id_rs1_data_o  = idex_q.rs1_data;
  assign id_rs2_data_o  = idex_q.rs2_data;
  assign id_imm_o       = idex_q.imm;
  assign id_rs1_o       = idex_q.rs1;
  assign id_rs2_o       = idex_q.rs2;
  assign id_rd_o        = idex_q.rd;
  assign id_funct3_o    = idex_q.funct3;
  assign id_alu_op_o    = idex_q.alu_op;
  assign id_alu_src_a_o = idex_q.alu_src_a;
  assign id_alu_src_b_o = idex_q.alu_src_b;
  assign id_mem_read_o  = idex_q.mem_read;
  assign id_mem_write_o = idex_q.mem_write;
  assign id_reg_write_o = idex_q.reg_write;
  assign id_wb_sel_o    = idex_q.wb_sel;
  assign id_branch_o    = idex_q.branch;
  assign id_jump_o      = idex_q.jump;
  assign id_jalr_o      = idex_q.jalr;
  assign id_illegal_o   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: expected ID/EX contents are queued
// when an instruction is driven and compared one edge later.
module tb_id_stage;

  localparam logic [31:0] RF1 = 32'hA5A5_0001;
  localparam logic [31:0] RF2 = 32'h5A5A_0002;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, if_instr;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        stall;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_a, id_alu_src_b, id_mem_read, id_mem_write, id_reg_write;
  logic [1:0]  id_wb_sel;
  logic        id_branch, id_jump, id_jalr, id_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc_i(if_pc), .if_instr_i(if_instr),
    .flush_i(flush), .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .rf_rs1_addr_o(rf_rs1_addr), .rf_rs2_addr_o(rf_rs2_addr),
    .rf_rs1_data_i(rf_rs1_data), .rf_rs2_data_i(rf_rs2_data),
    .stall_o(stall),
    .id_pc_o(id_pc), .id_rs1_data_o(id_rs1_data), .id_rs2_data_o(id_rs2_data),
    .id_imm_o(id_imm), .id_rs1_o(id_rs1), .id_rs2_o(id_rs2), .id_rd_o(id_rd),
    .id_funct3_o(id_funct3), .id_alu_op_o(id_alu_op),
    .id_alu_src_a_o(id_alu_src_a), .id_alu_src_b_o(id_alu_src_b),
    .id_mem_read_o(id_mem_read), .id_mem_write_o(id_mem_write),
    .id_reg_write_o(id_reg_write), .id_wb_sel_o(id_wb_sel),
    .id_branch_o(id_branch), .id_jump_o(id_jump), .id_jalr_o(id_jalr),
    .id_illegal_o(id_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [3:0] alu,
                              input logic src_a, input logic src_b, input logic rw);
    exp_t e;
    e           = '0;
    e.pc        = pc;
    e.imm       = imm;
    e.rd        = rd;
    e.alu_op    = alu;
    e.alu_src_a = src_a;
    e.alu_src_b = src_b;
    e.reg_write = rw;
    return e;
  endfunction

  task automatic compare(input string n, input exp_t e);
    check({n, ".pc"},        id_pc,        e.pc);
    check({n, ".rs1_data"},  id_rs1_data,  e.rs1_data);
    check({n, ".rs2_data"},  id_rs2_data,  e.rs2_data);
    check({n, ".imm"},       id_imm,       e.imm);
    check({n, ".rs1"},       {27'd0, id_rs1},    {27'd0, e.rs1});
    check({n, ".rs2"},       {27'd0, id_rs2},    {27'd0, e.rs2});
    check({n, ".rd"},        {27'd0, id_rd},     {27'd0, e.rd});
    check({n, ".funct3"},    {29'd0, id_funct3}, {29'd0, e.funct3});
    check({n, ".alu_op"},    {28'd0, id_alu_op}, {28'd0, e.alu_op});
    check({n, ".alu_src_a"}, {31'd0, id_alu_src_a}, {31'd0, e.alu_src_a});
    check({n, ".alu_src_b"}, {31'd0, id_alu_src_b}, {31'd0, e.alu_src_b});
    check({n, ".mem_read"},  {31'd0, id_mem_read},  {31'd0, e.mem_read});
    check({n, ".mem_write"}, {31'd0, id_mem_write}, {31'd0, e.mem_write});
    check({n, ".reg_write"}, {31'd0, id_reg_write}, {31'd0, e.reg_write});
    check({n, ".wb_sel"},    {30'd0, id_wb_sel},    {30'd0, e.wb_sel});
    check({n, ".branch"},    {31'd0, id_branch},    {31'd0, e.branch});
    check({n, ".jump"},      {31'd0, id_jump},      {31'd0, e.jump});
    check({n, ".jalr"},      {31'd0, id_jalr},      {31'd0, e.jalr});
    check({n, ".illegal"},   {31'd0, id_illegal},   {31'd0, e.illegal});
  endtask

  // Drive one instruction, check the combinational outputs, then pop and
  // compare the registered result after the next rising edge.
  task automatic step(input string n, input logic [31:0] instr, input logic [31:0] pc,
                      input logic exp_stall, input exp_t e);
    exp_t got;
    if_instr = instr;
    if_pc    = pc;
    sb.push_back(e);
    #1;
    check({n, ".stall"},    {31'd0, stall},       {31'd0, exp_stall});
    check({n, ".rf_addr1"}, {27'd0, rf_rs1_addr}, {27'd0, instr[19:15]});
    check({n, ".rf_addr2"}, {27'd0, rf_rs2_addr}, {27'd0, instr[24:20]});
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare(n, got);
  endtask

  task automatic quiet();
    flush       = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    wb_we       = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'd0;
    rf_rs1_data = RF1;
    rf_rs2_data = RF2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    if_pc    = 32'd0;
    if_instr = 32'd0;
    quiet();
    repeat (2) @(posedge clk);
    #1;

    // Reset with a load-use pattern present: no stall, ID/EX all zero.
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    step("rst", 32'h00108133, 32'h08, 1'b0, '0);
    rst_n = 1'b1;
    quiet();

    // addi x1,x0,5
    e = mk(32'h10, 32'd5, 5'd1, 4'd0, 1'b0, 1'b1, 1'b1);
    step("addi", 32'h00500093, 32'h10, 1'b0, e);

    // add x2,x1,x1 while a load to x1 is in EX
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    step("lduse", 32'h00108133, 32'h14, 1'b1, '0);
    quiet();

    e = mk(32'h14, 32'd0, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
    e.rs1 = 5'd1; e.rs2 = 5'd1; e.rs1_data = RF1; e.rs2_data = RF2;
    step("add", 32'h00108133, 32'h14, 1'b0, e);

    // addi x4,x3,0 with WB writing x3 this cycle
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    e = mk(32'h18, 32'd0, 5'd4, 4'd0, 1'b0, 1'b1, 1'b1);
    e.rs1 = 5'd3; e.rs1_data = 32'hDEAD;
    step("wbbyp", 32'h00018213, 32'h18, 1'b0, e);

    // Same address but WB not enabling: register file value is used
    wb_we = 1'b0; rf_rs1_data = 32'h77;
    e = mk(32'h1C, 32'd0, 5'd4, 4'd0, 1'b0, 1'b1, 1'b1);
    e.rs1 = 5'd3; e.rs1_data = 32'h77;
    step("wboff", 32'h00018213, 32'h1C, 1'b0, e);
    quiet();

    // Flush beats the load-use stall
    flush = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd1;
    step("flush", 32'h00108133, 32'h20, 1'b0, '0);
    quiet();

    // beq x0,x0,-4
    e = mk(32'h40, 32'hFFFF_FFFC, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    e.branch = 1'b1;
    step("beq", 32'hFE000EE3, 32'h40, 1'b0, e);

    e = '0; e.illegal = 1'b1;
    step("illegal", 32'hFFFF_FFFF, 32'h44, 1'b0, e);

    // lw x5,8(x2): illegal must have dropped after one cycle
    e = mk(32'h48, 32'd8, 5'd5, 4'd0, 1'b0, 1'b1, 1'b1);
    e.rs1 = 5'd2; e.rs1_data = RF1; e.funct3 = 3'd2; e.mem_read = 1'b1; e.wb_sel = 2'd1;
    step("lw", 32'h00812283, 32'h48, 1'b0, e);

    // sw x6,-4(x2)
    e = mk(32'h4C, 32'hFFFF_FFFC, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    e.rs1 = 5'd2; e.rs2 = 5'd6; e.rs1_data = RF1; e.rs2_data = RF2;
    e.funct3 = 3'd2; e.mem_write = 1'b1;
    step("sw", 32'hFE612E23, 32'h4C, 1'b0, e);

    // lui x7,0xABCDE
    e = mk(32'h50, 32'hABCD_E000, 5'd7, 4'd10, 1'b0, 1'b1, 1'b1);
    step("lui", 32'hABCDE3B7, 32'h50, 1'b0, e);

    // jal x1,+8
    e = mk(32'h54, 32'd8, 5'd1, 4'd0, 1'b1, 1'b1, 1'b1);
    e.jump = 1'b1; e.wb_sel = 2'd2;
    step("jal", 32'h008000EF, 32'h54, 1'b0, e);

    // srai x8,x9,3
    e = mk(32'h58, 32'h0000_0403, 5'd8, 4'd7, 1'b0, 1'b1, 1'b1);
    e.rs1 = 5'd9; e.rs1_data = RF1; e.funct3 = 3'd5;
    step("srai", 32'h4034D413, 32'h58, 1'b0, e);

    // sub x10,x11,x12 with WB bypass on rs2
    wb_we = 1'b1; wb_rd = 5'd12; wb_data = 32'h1234;
    e = mk(32'h5C, 32'd0, 5'd10, 4'd1, 1'b0, 1'b0, 1'b1);
    e.rs1 = 5'd11; e.rs2 = 5'd12; e.rs1_data = RF1; e.rs2_data = 32'h1234;
    step("sub", 32'h40C58533, 32'h5C, 1'b0, e);
    quiet();

    // Reset mid-stream over non-zero ID/EX contents
    rst_n = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd1;
    step("mid_rst", 32'h00108133, 32'h60, 1'b0, '0);
    rst_n = 1'b1;
    quiet();

    e = mk(32'h70, 32'd5, 5'd1, 4'd0, 1'b0, 1'b1, 1'b1);
    step("post_rst", 32'h00500093, 32'h70, 1'b0, e);

    // addi x0,x0,0: rd==0 never writes
    e = mk(32'h74, 32'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step("nop_rd0", 32'h0000_0013, 32'h74, 1'b0, e);

    step("zero", 32'h0000_0000, 32'h78, 1'b0, '0);

    e = '0; e.illegal = 1'b1;
    step("rvc", 32'h0000_0001, 32'h7C, 1'b0, e);

    step("fence", 32'h0000_000F, 32'h80, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
